gray2rgb_colormap: RTL

//  Inverse-direction partner of the RGB-to-gray stage: expands a 10-bit grayscale pixel stream

---
 rtl/gray2rgb_pkg.sv | 7 +
 rtl/jet_lut.sv | 24 ++
 rtl/gray2rgb_colormap.sv | 122 ++++++++++++
 3 files changed

// File: rtl/gray2rgb_pkg.sv
// gray2rgb_pkg: shared mode encodings for the gray-to-RGB colormap stage.
package gray2rgb_pkg;
    localparam logic [1:0] MODE_GRAY = 2'd0;
    localparam logic [1:0] MODE_JET  = 2'd1;
    localparam logic [1:0] MODE_THR  = 2'd2;
    localparam logic [1:0] MODE_INV  = 2'd3;
endpackage

// File: rtl/jet_lut.sv
// jet_lut: combinational jet false-color map, four linear ramps selected by the top two bits.
module jet_lut #(
    parameter int DATA_W = 10
) (
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_r,
    output logic [DATA_W-1:0] o_g,
    output logic [DATA_W-1:0] o_b
);
    logic [1:0]        w_seg;
    logic [DATA_W-1:0] w_t;
    logic [DATA_W-1:0] w_m;

    assign w_seg = i_x[DATA_W-1 -: 2];
    // Stretch the in-segment offset to full scale by replicating its top bits.
    assign w_t   = {i_x[DATA_W-3:0], i_x[DATA_W-3 -: 2]};
    assign w_m   = '1;

    always_comb begin
        o_r = w_seg == 2'd2 ? w_t : w_seg == 2'd3 ? w_m : '0;
        o_g = w_seg == 2'd0 ? w_t : w_seg == 2'd3 ? w_m - w_t : w_m;
        o_b = w_seg == 2'd0 ? w_m : w_seg == 2'd1 ? w_m - w_t : '0;
    end
endmodule

// File: rtl/gray2rgb_colormap.sv
// gray2rgb_colormap: 2-stage gray-to-RGB expansion with per-frame config latch and
// per-frame count of dark (below-threshold) pixels.
module gray2rgb_colormap
    import gray2rgb_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 20
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iDVAL,
    input  logic              iFVAL,
    input  logic [DATA_W-1:0] iDATA,
    input  logic [1:0]        iMODE,
    input  logic [DATA_W-1:0] iTHRESH,
    output logic              oDVAL,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic [CNT_W-1:0]  oHIT_CNT,
    output logic              oCNT_VALID
);
    logic [1:0]        r_cfg_mode;
    logic [DATA_W-1:0] r_cfg_thr;
    logic              r_fval_d;
    logic              r_active;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_dval1;
    logic [DATA_W-1:0] r_x1;
    logic [1:0]        r_mode1;
    logic              r_hit1;

    logic              w_rise;
    logic              w_fall;
    logic [1:0]        w_mode;
    logic [DATA_W-1:0] w_thr;
    logic              w_hit;
    logic [DATA_W-1:0] w_jr, w_jg, w_jb;
    logic [DATA_W-1:0] w_r, w_g, w_b;

    // On the rising edge the incoming config applies to that same pixel.
    assign w_rise = iFVAL & ~r_fval_d;
    assign w_fall = ~iFVAL & r_fval_d & r_active;
    assign w_mode = w_rise ? iMODE : r_cfg_mode;
    assign w_thr  = w_rise ? iTHRESH : r_cfg_thr;
    assign w_hit  = iDATA < w_thr;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_cfg_mode <= MODE_GRAY;
            r_cfg_thr  <= '0;
            r_fval_d   <= 1'b1;
            r_active   <= 1'b0;
            r_cnt      <= '0;
            oHIT_CNT   <= '0;
            oCNT_VALID <= 1'b0;
        end else begin
            r_fval_d   <= iFVAL;
            oCNT_VALID <= w_fall;
            if (w_rise) begin
                r_cfg_mode <= iMODE;
                r_cfg_thr  <= iTHRESH;
                r_active   <= 1'b1;
                r_cnt      <= CNT_W'(iDVAL & w_hit);
            end else if (iFVAL & iDVAL & w_hit & ~&r_cnt) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_fall) begin
                r_active <= 1'b0;
                oHIT_CNT <= r_cnt;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_dval1 <= 1'b0;
            r_x1    <= '0;
            r_mode1 <= MODE_GRAY;
            r_hit1  <= 1'b0;
            oDVAL   <= 1'b0;
            oRed    <= '0;
            oGreen  <= '0;
            oBlue   <= '0;
        end else begin
            r_dval1 <= iDVAL;
            r_x1    <= iDATA;
            r_mode1 <= w_mode;
            r_hit1  <= w_hit;
            oDVAL   <= r_dval1;
            oRed    <= w_r;
            oGreen  <= w_g;
            oBlue   <= w_b;
        end
    end

    jet_lut #(.DATA_W(DATA_W)) u_jet (
        .i_x(r_x1),
        .o_r(w_jr),
        .o_g(w_jg),
        .o_b(w_jb)
    );

    always_comb begin
        w_r = r_x1;
        w_g = r_x1;
        w_b = r_x1;
        if (r_mode1 == MODE_JET) begin
            w_r = w_jr;
            w_g = w_jg;
            w_b = w_jb;
        end else if (r_mode1 == MODE_INV) begin
            w_r = ~r_x1;
            w_g = ~r_x1;
            w_b = ~r_x1;
        end else if (r_mode1 == MODE_THR && r_hit1) begin
            w_r = '1;
            w_g = '0;
            w_b = '0;
        end
    end
endmodule
